mux_arb_rr: RTL and testbench
=============================

# mux_arb_rr

Parametrised N-channel arbitrated multiplexer: the registered, handshaked successor to the datapath 3:1 select mux. It takes NCH valid/ready source channels of NBITS each, picks one per cycle by round-robin or fixed priority, and presents it on a single registered valid/ready output together with the winning channel index. It sits between multiple producers, such as pipeline write-back sources or debug/UART request queues, and one shared consumer.

## Interface
- NBITS, 32, data width per channel (1..64)
- NCH, 4, number of input channels (2..8)
- SELW, derived localparam = clog2(NCH), width of the channel index
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
- in_data  input  NCH*NBITS  packed channel data; channel i is in_data[i*NBITS +: NBITS]
- in_valid  input  NCH  per-channel request
- in_ready  output  NCH  per-channel accept; one-hot or zero
- out_data  output  NBITS  registered selected data
- out_sel  output  SELW  registered index of the channel that produced out_data
- out_valid  output  1  out_data/out_sel hold a beat
- out_ready  input  1  consumer accepts the beat

## Operation
- Output stage is a single register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = ~out_valid | out_ready. The register loads whenever it is empty or being drained in the same cycle.
- Grant is combinational from in_valid, mode and the pointer ptr[SELW-1:0].
  - Round-robin: the first valid channel at or after ptr, scanning upward modulo NCH.
  - Fixed: the lowest-index valid channel. ptr is ignored.
- in_ready[i] = grant[i] & load_en. At most one bit is set, and it is never set for a channel with in_valid=0.
- A transfer on channel k occurs when in_valid[k] & in_ready[k]. On that edge: out_data <= channel k data, out_sel <= k, out_valid <= 1.
- Round-robin pointer: on a transfer from channel k, ptr <= (k+1) mod NCH, wrapping correctly when NCH is not a power of two.
- Fixed mode: ptr does not update.
- Drain without load: when out_valid & out_ready and there is no transfer, out_valid <= 0. out_data and out_sel keep their last value.
- Drain and load in the same cycle: the new beat replaces the old one with no bubble.
- No valid inputs: there is no grant, all in_ready bits are 0, and state changes only by draining.
- Sources must hold in_data stable while in_valid is high and not yet accepted. The block does not register inputs.
- A mode change takes effect on the next arbitration. ptr is retained across mode changes.
- Reset mid-operation: any held beat is discarded and there is no partial output.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready=0 while reset is asserted.
- Latency: a beat accepted at edge n is visible on the outputs after edge n, with out_valid=1 in cycle n+1.
- Throughput: one beat per cycle while out_ready=1.
- in_ready has a combinational path from out_ready, in_valid and mode. There is no combinational path from in_data to any output.
- While out_valid=1 & out_ready=0: out_data, out_sel and out_valid hold, and all in_ready bits are 0.
- Round-robin fairness: with all channels continuously valid, each channel is granted exactly once in every NCH consecutive transfers.

## Test plan
- Reset: assert reset mid-burst with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately (asynchronous). After release, the first grant goes to channel 0 when all channels are valid.
- Round-robin sweep: NCH=4, all in_valid=1, out_ready=1 -> out_sel sequence 0,1,2,3,0,1,… on consecutive cycles, out_data matches each channel, no bubbles.
- Wrap with sparse requests: in_valid=4'b1001, ptr=1 -> channel 3 granted, then channel 0, then channel 3. With NCH=3, a transfer from channel 2 wraps ptr to 0.
- Backpressure: hold out_ready=0 for 5 cycles with channel 2 valid -> out_valid, out_data and out_sel stable and in_ready=0. Raise out_ready -> drain and load of the next beat in the same cycle.
- Fixed priority: mode=1 with channels 0 and 3 valid for 6 cycles -> out_sel=0 every cycle and ptr unchanged. Switch to mode=0 -> the next grant follows the retained ptr.
- Idle drain: a single beat from channel 1, then in_valid=0 and out_ready=1 -> out_valid=1 for one cycle, then 0, with out_sel holding at 1.

Source files
------------

// File: rtl/mux_arb_rr.sv
// N-channel arbitrated multiplexer: round-robin or fixed-priority grant feeding
// a single registered valid/ready output stage that also reports the winning index.
module mux_arb_rr #(
  parameter int NBITS = 32,
  parameter int NCH   = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [NCH*NBITS-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [NBITS-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_found;
  logic [NBITS-1:0] gnt_data;
  logic             load_en;
  logic             transfer;

  assign load_en  = (state_q == EMPTY) | out_ready;
  assign transfer = gnt_found & load_en & ~reset;
  assign in_ready = reset ? '0 : (grant & {NCH{load_en}});

  // Scan NCH positions starting at ptr (round-robin) or at 0 (fixed); first valid wins.
  always_comb begin
    logic [SELW:0]   sum;
    logic [SELW-1:0] idx;
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < NCH; off++) begin
      sum = mode ? (SELW+1)'(off) : ({1'b0, ptr_q} + (SELW+1)'(off));
      if (sum >= (SELW+1)'(NCH)) sum = sum - (SELW+1)'(NCH);
      idx = sum[SELW-1:0];
      if (!gnt_found && in_valid[idx]) begin
        gnt_found  = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) gnt_data = in_data[i*NBITS +: NBITS];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (transfer) begin
      state_d = FULL;
      data_d  = gnt_data;
      sel_d   = gnt_idx;
      if (!mode) ptr_d = (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    out_valid = (state_q == FULL);
    out_data  = data_q;
    out_sel   = sel_q;
  end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Directed bench for mux_arb_rr: a 4-channel/32-bit instance plus a 3-channel/8-bit
// instance for non-power-of-two pointer wrap.
module tb_mux_arb_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [127:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;
  logic        out_ready3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_arb_rr #(.NBITS(32), .NCH(4)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_arb_rr #(.NBITS(8), .NCH(3)) dut3 (
    .clk(clk), .reset(reset), .mode(1'b0),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  function automatic logic [31:0] dat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  task automatic set_ch(input int ch, input logic [31:0] v);
    in_data[ch*32 +: 32] = v;
  endtask

  task automatic load_default_data();
    for (int i = 0; i < 4; i++) set_ch(i, dat(i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 4'b0000;
    in_valid3 = 3'b000;
    mode      = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    load_default_data();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    in_valid3 = 3'b000; out_ready3 = 1'b1;
    load_default_data();
    in_data3 = {8'h33, 8'h22, 8'h11};
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", out_data); end
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d want=0", out_sel); end
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rst_inready got=%b want=0000", in_ready); end
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b want=0001", in_ready); end
    step();
    step();
    total++; if (out_valid !== 1'b1 || out_sel !== 2'd1) begin bad++; $display("FAIL burst_sel got=%0b/%0d want=1/1", out_valid, out_sel); end
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0)
      begin bad++; $display("FAIL async_rst got=%0b/%h/%0d want=0/0/0", out_valid, out_data, out_sel); end
    step();
    reset = 1'b0;
    step();
    total++; if (out_sel !== 2'd0 || out_data !== dat(0) || out_valid !== 1'b1)
      begin bad++; $display("FAIL post_rst_grant got=%0d/%h want=0/%h", out_sel, out_data, dat(0)); end
  endtask

  task automatic test_rr_sweep();
    do_reset();
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== dat(i % 4))
        begin bad++; $display("FAIL rr_sweep[%0d] got=%0b/%0d/%h want=1/%0d/%h", i, out_valid, out_sel, out_data, i % 4, dat(i % 4)); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 4'b0001;
    step();
    in_valid = 4'b1001;
    #1;
    total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_rdy3 got=%b want=1000", in_ready); end
    step();
    total++; if (out_sel !== 2'd3) begin bad++; $display("FAIL wrap_sel3 got=%0d want=3", out_sel); end
    step();
    total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL wrap_sel0 got=%0d want=0", out_sel); end
    step();
    total++; if (out_sel !== 2'd3) begin bad++; $display("FAIL wrap_sel3b got=%0d want=3", out_sel); end
    in_valid = 4'b0000;
    out_ready3 = 1'b1;
    in_valid3 = 3'b100;
    step();
    total++; if (out_sel3 !== 2'd2 || out_data3 !== 8'h33) begin bad++; $display("FAIL n3_sel2 got=%0d/%h want=2/33", out_sel3, out_data3); end
    in_valid3 = 3'b111;
    #1;
    total++; if (in_ready3 !== 3'b001) begin bad++; $display("FAIL n3_wrap got=%b want=001", in_ready3); end
    step();
    total++; if (out_sel3 !== 2'd0 || out_data3 !== 8'h11) begin bad++; $display("FAIL n3_sel0 got=%0d/%h want=0/11", out_sel3, out_data3); end
    in_valid3 = 3'b000;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    step();
    set_ch(2, 32'hBEEF_0002);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== dat(2) || in_ready !== 4'b0000)
        begin bad++; $display("FAIL bp_hold[%0d] got=%0b/%0d/%h/%b want=1/2/%h/0000", i, out_valid, out_sel, out_data, in_ready, dat(2)); end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release got=%b want=0100", in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'hBEEF_0002)
      begin bad++; $display("FAIL bp_reload got=%0b/%h want=1/beef0002", out_valid, out_data); end
    in_valid = 4'b0000;
  endtask

  task automatic test_fixed();
    do_reset();
    in_valid = 4'b0010;
    step();
    mode = 1'b1;
    in_valid = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (out_sel !== 2'd0 || out_data !== dat(0))
        begin bad++; $display("FAIL fixed[%0d] got=%0d want=0", i, out_sel); end
    end
    mode = 1'b0;
    in_valid = 4'b1011;
    #1;
    total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL fixed_ptr_kept got=%b want=1000", in_ready); end
    step();
    total++; if (out_sel !== 2'd3) begin bad++; $display("FAIL fixed_to_rr got=%0d want=3", out_sel); end
    in_valid = 4'b0000;
  endtask

  task automatic test_idle_drain();
    do_reset();
    in_valid = 4'b0010;
    step();
    in_valid = 4'b0000;
    total++; if (out_valid !== 1'b1 || out_sel !== 2'd1) begin bad++; $display("FAIL idle_beat got=%0b/%0d want=1/1", out_valid, out_sel); end
    step();
    total++; if (out_valid !== 1'b0 || out_sel !== 2'd1 || out_data !== dat(1))
      begin bad++; $display("FAIL idle_drain got=%0b/%0d/%h want=0/1/%h", out_valid, out_sel, out_data, dat(1)); end
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 4'b0000)
      begin bad++; $display("FAIL idle_stay got=%0b/%b want=0/0000", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_rr_sweep();
    test_wrap();
    test_backpressure();
    test_fixed();
    test_idle_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
